// File: rtl/spi_reg_bridge.sv
// Byte-level SPI command decoder onto a 128-entry register space; CS_n is synchronized in.
// SPI_REG_BRIDGE_AUTOINC_EN enables burst address auto-increment with 7-bit wrap.
module spi_reg_bridge #(
  parameter logic [7:0] STATUS_BYTE = 8'hA4
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_RX_DV,
  input  logic [7:0] i_RX_Byte,
  output logic       o_TX_DV,
  output logic [7:0] o_TX_Byte,
  input  logic       i_SPI_CS_n,
  output logic [6:0] o_Reg_Addr,
  output logic       o_Reg_Wr_En,
  output logic [7:0] o_Reg_Wr_Data,
  output logic       o_Reg_Rd_En,
  input  logic [7:0] i_Reg_Rd_Data,
  output logic       o_Overrun
);

  typedef enum logic [2:0] {
    S_INIT,
    S_CMD,
    S_RD_FETCH,
    S_RD_LOAD,
    S_RD,
    S_WR
  } state_t;

  state_t     r_state;
  logic       r_cs_meta;
  logic       r_cs_sync;
  logic       r_cs_prev;
  logic       r_tx_dv;
  logic [7:0] r_tx_byte;
  logic [6:0] r_addr;
  logic       r_wr_en;
  logic [7:0] r_wr_data;
  logic       r_rd_en;
  logic       r_overrun;

  logic       w_cs_rise;
  logic [7:0] w_status;
  logic [6:0] w_addr_next;

  assign w_cs_rise = r_cs_sync & ~r_cs_prev;
  assign w_status  = {STATUS_BYTE[7:1], r_overrun};

`ifdef SPI_REG_BRIDGE_AUTOINC_EN
  assign w_addr_next = r_addr + 7'd1;
`else
  assign w_addr_next = r_addr;
`endif

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_cs_meta <= 1'b1;
      r_cs_sync <= 1'b1;
      r_cs_prev <= 1'b1;
    end else begin
      r_cs_meta <= i_SPI_CS_n;
      r_cs_sync <= r_cs_meta;
      r_cs_prev <= r_cs_sync;
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_state   <= S_INIT;
      r_tx_dv   <= 1'b0;
      r_tx_byte <= 8'h00;
      r_addr    <= 7'h00;
      r_wr_en   <= 1'b0;
      r_wr_data <= 8'h00;
      r_rd_en   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_tx_dv <= 1'b0;
      r_wr_en <= 1'b0;
      r_rd_en <= 1'b0;
      // Post-write advance; a command latch later in this block overrides it.
      if (r_wr_en) r_addr <= w_addr_next;

      if (r_state != S_INIT && w_cs_rise) begin
        r_state   <= S_CMD;
        r_tx_dv   <= 1'b1;
        r_tx_byte <= w_status;
        if (r_state == S_WR && i_RX_DV) begin
          r_wr_en   <= 1'b1;
          r_wr_data <= i_RX_Byte;
        end
        if ((r_state == S_RD_FETCH || r_state == S_RD_LOAD) && i_RX_DV)
          r_overrun <= 1'b1;
      end else begin
        case (r_state)
          S_INIT: begin
            r_state   <= S_CMD;
            r_tx_dv   <= 1'b1;
            r_tx_byte <= w_status;
          end
          S_CMD: begin
            if (i_RX_DV) begin
              r_addr <= i_RX_Byte[6:0];
              if (i_RX_Byte[7]) begin
                r_rd_en <= 1'b1;
                r_state <= S_RD_FETCH;
              end else begin
                r_state <= S_WR;
              end
            end
          end
          S_RD_FETCH: begin
            if (i_RX_DV) r_overrun <= 1'b1;
            r_state <= S_RD_LOAD;
          end
          S_RD_LOAD: begin
            if (i_RX_DV) r_overrun <= 1'b1;
            r_tx_dv   <= 1'b1;
            r_tx_byte <= i_Reg_Rd_Data;
            r_state   <= S_RD;
          end
          S_RD: begin
            if (i_RX_DV) begin
              r_addr  <= w_addr_next;
              r_rd_en <= 1'b1;
              r_state <= S_RD_FETCH;
            end
          end
          S_WR: begin
            if (i_RX_DV) begin
              r_wr_en   <= 1'b1;
              r_wr_data <= i_RX_Byte;
              r_tx_dv   <= 1'b1;
              r_tx_byte <= i_RX_Byte;
            end
          end
          default: r_state <= S_INIT;
        endcase
      end
    end
  end

  assign o_TX_DV       = r_tx_dv;
  assign o_TX_Byte     = r_tx_byte;
  assign o_Reg_Addr    = r_addr;
  assign o_Reg_Wr_En   = r_wr_en;
  assign o_Reg_Wr_Data = r_wr_data;
  assign o_Reg_Rd_En   = r_rd_en;
  assign o_Overrun     = r_overrun;

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Bench for spi_reg_bridge: transaction-level model of expected strobes and MISO bytes.
module tb_spi_reg_bridge;

  logic       clk = 1'b0;
  logic       i_Rst_L;
  logic       i_RX_DV;
  logic [7:0] i_RX_Byte;
  logic       o_TX_DV;
  logic [7:0] o_TX_Byte;
  logic       i_SPI_CS_n;
  logic [6:0] o_Reg_Addr;
  logic       o_Reg_Wr_En;
  logic [7:0] o_Reg_Wr_Data;
  logic       o_Reg_Rd_En;
  logic [7:0] i_Reg_Rd_Data;
  logic       o_Overrun;

  spi_reg_bridge dut (
    .i_Clk         (clk),
    .i_Rst_L       (i_Rst_L),
    .i_RX_DV       (i_RX_DV),
    .i_RX_Byte     (i_RX_Byte),
    .o_TX_DV       (o_TX_DV),
    .o_TX_Byte     (o_TX_Byte),
    .i_SPI_CS_n    (i_SPI_CS_n),
    .o_Reg_Addr    (o_Reg_Addr),
    .o_Reg_Wr_En   (o_Reg_Wr_En),
    .o_Reg_Wr_Data (o_Reg_Wr_Data),
    .o_Reg_Rd_En   (o_Reg_Rd_En),
    .i_Reg_Rd_Data (i_Reg_Rd_Data),
    .o_Overrun     (o_Overrun)
  );

`ifdef SPI_REG_BRIDGE_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Register space seen by the DUT, and the bench's own expectation of its contents.
  logic [7:0] mem    [128];
  logic [7:0] shadow [128];
  always @(posedge clk) begin
    if (o_Reg_Wr_En) mem[o_Reg_Addr] <= o_Reg_Wr_Data;
    if (o_Reg_Rd_En) i_Reg_Rd_Data <= mem[o_Reg_Addr];
  end

  int tx_b[$], tx_c[$], rd_a[$], rd_c[$], wr_a[$], wr_d[$], wr_c[$];
  int ex_tx_b[$], ex_tx_c[$], ex_rd_a[$], ex_rd_c[$], ex_wr_a[$], ex_wr_d[$], ex_wr_c[$];
  logic [7:0] wdat[$];
  bit exp_ovr = 1'b0;

  always @(negedge clk) begin
    if (o_TX_DV)     begin tx_b.push_back(int'(o_TX_Byte)); tx_c.push_back(cyc); end
    if (o_Reg_Rd_En) begin rd_a.push_back(int'(o_Reg_Addr)); rd_c.push_back(cyc); end
    if (o_Reg_Wr_En) begin
      wr_a.push_back(int'(o_Reg_Addr)); wr_d.push_back(int'(o_Reg_Wr_Data)); wr_c.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] addr_at(input logic [6:0] a, input int i);
    logic [6:0] r;
    r = AUTOINC ? 7'((int'(a) + i) % 128) : a;
    return r;
  endfunction

  function automatic int status_byte();
    return (8'hA4 & 8'hFE) | int'(exp_ovr);
  endfunction

  task automatic clear_logs();
    tx_b.delete(); tx_c.delete(); rd_a.delete(); rd_c.delete();
    wr_a.delete(); wr_d.delete(); wr_c.delete();
    ex_tx_b.delete(); ex_tx_c.delete(); ex_rd_a.delete(); ex_rd_c.delete();
    ex_wr_a.delete(); ex_wr_d.delete(); ex_wr_c.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, output int c);
    @(posedge clk); #1;
    i_RX_DV = 1'b1; i_RX_Byte = b; c = cyc;
    @(posedge clk); #1;
    i_RX_DV = 1'b0;
  endtask

  task automatic compare(input string tag);
    chk({tag, " tx_count"}, tx_b.size(), ex_tx_b.size());
    for (int i = 0; i < ex_tx_b.size() && i < tx_b.size(); i++) begin
      chk($sformatf("%s tx_byte[%0d]", tag, i), tx_b[i], ex_tx_b[i]);
      chk($sformatf("%s tx_cycle[%0d]", tag, i), tx_c[i], ex_tx_c[i]);
    end
    chk({tag, " rd_count"}, rd_a.size(), ex_rd_a.size());
    for (int i = 0; i < ex_rd_a.size() && i < rd_a.size(); i++) begin
      chk($sformatf("%s rd_addr[%0d]", tag, i), rd_a[i], ex_rd_a[i]);
      chk($sformatf("%s rd_cycle[%0d]", tag, i), rd_c[i], ex_rd_c[i]);
    end
    chk({tag, " wr_count"}, wr_a.size(), ex_wr_a.size());
    for (int i = 0; i < ex_wr_a.size() && i < wr_a.size(); i++) begin
      chk($sformatf("%s wr_addr[%0d]", tag, i), wr_a[i], ex_wr_a[i]);
      chk($sformatf("%s wr_data[%0d]", tag, i), wr_d[i], ex_wr_d[i]);
      chk($sformatf("%s wr_cycle[%0d]", tag, i), wr_c[i], ex_wr_c[i]);
    end
  endtask

  task automatic begin_txn();
    i_SPI_CS_n = 1'b0;
    idle(3);
    clear_logs();
  endtask

  task automatic end_txn(input string tag);
    int cs_c;
    i_SPI_CS_n = 1'b1;
    cs_c = cyc;
    idle(8);
    // Pin edge to status load: two synchronizer flops plus the edge-detect register.
    ex_tx_b.push_back(status_byte()); ex_tx_c.push_back(cs_c + 3);
    compare(tag);
  endtask

  task automatic do_write(input string tag, input logic [6:0] a);
    int c;
    logic [6:0] ad;
    begin_txn();
    send_byte({1'b0, a}, c);
    idle(4);
    for (int i = 0; i < wdat.size(); i++) begin
      send_byte(wdat[i], c);
      ad = addr_at(a, i);
      ex_wr_a.push_back(int'(ad)); ex_wr_d.push_back(int'(wdat[i])); ex_wr_c.push_back(c + 1);
      ex_tx_b.push_back(int'(wdat[i])); ex_tx_c.push_back(c + 1);
      shadow[ad] = wdat[i];
      idle(4);
    end
    end_txn(tag);
  endtask

  task automatic do_read(input string tag, input logic [6:0] a, input int dummies);
    int c;
    logic [6:0] ad;
    begin_txn();
    for (int j = 0; j <= dummies; j++) begin
      if (j == 0) send_byte({1'b1, a}, c);
      else        send_byte(8'($urandom), c);
      ad = addr_at(a, j);
      ex_rd_a.push_back(int'(ad)); ex_rd_c.push_back(c + 1);
      ex_tx_b.push_back(int'(shadow[ad])); ex_tx_c.push_back(c + 3);
      idle(5);
    end
    end_txn(tag);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " tx_dv"}, int'(o_TX_DV), 0);
    chk({tag, " tx_byte"}, int'(o_TX_Byte), 0);
    chk({tag, " addr"}, int'(o_Reg_Addr), 0);
    chk({tag, " wr_en"}, int'(o_Reg_Wr_En), 0);
    chk({tag, " wr_data"}, int'(o_Reg_Wr_Data), 0);
    chk({tag, " rd_en"}, int'(o_Reg_Rd_En), 0);
    chk({tag, " overrun"}, int'(o_Overrun), 0);
  endtask

  initial begin
    int c;
    int rel;
    logic [6:0] ra;
    int n;

    i_Rst_L = 1'b1; i_SPI_CS_n = 1'b1; i_RX_DV = 1'b0; i_RX_Byte = 8'h00;
    for (int a = 0; a < 128; a++) begin
      mem[a] = 8'(a + 1);
      shadow[a] = 8'(a + 1);
    end

    // Power-on reset and the single status preload that follows it
    #2 i_Rst_L = 1'b0;
    #1 chk_reset_outputs("por");
    idle(3);
    clear_logs();
    i_Rst_L = 1'b1;
    rel = cyc;
    idle(5);
    ex_tx_b.push_back(8'hA4); ex_tx_c.push_back(rel + 1);
    compare("por_status");
    chk("por addr", int'(o_Reg_Addr), 0);
    chk("por overrun", int'(o_Overrun), 0);

    // Directed two-byte write burst at 0x05
    wdat.delete(); wdat.push_back(8'h3C); wdat.push_back(8'hC3);
    do_write("wr05", 7'h05);

    // Directed read at 0x10 with two dummies
    do_read("rd10", 7'h10, 2);

    // Read at the top of the address space: wraps under auto-increment
    do_read("rd7f", 7'h7F, 1);

    // Randomized write bursts followed by read-back of the same range
    for (int t = 0; t < 4; t++) begin
      ra = 7'($urandom);
      n = int'($urandom_range(1, 4));
      wdat.delete();
      for (int i = 0; i < n; i++) wdat.push_back(8'($urandom));
      do_write($sformatf("rnd_wr%0d", t), ra);
      do_read($sformatf("rnd_rd%0d", t), ra, n - 1);
    end

    // Byte arriving during a read fetch is dropped and flags overrun
    begin_txn();
    @(posedge clk); #1;
    i_RX_DV = 1'b1; i_RX_Byte = 8'hA0; c = cyc;
    @(posedge clk); #1;
    i_RX_Byte = 8'h55;
    @(posedge clk); #1;
    i_RX_DV = 1'b0;
    ex_rd_a.push_back(8'h20); ex_rd_c.push_back(c + 1);
    ex_tx_b.push_back(int'(shadow[7'h20])); ex_tx_c.push_back(c + 3);
    idle(5);
    chk("ovr flag", int'(o_Overrun), 1);
    exp_ovr = 1'b1;
    end_txn("ovr");
    chk("ovr status_byte", tx_b.size() > 0 ? tx_b[tx_b.size() - 1] : -1, 8'hA5);

    // Reset asserted while the read strobe is out
    begin_txn();
    send_byte(8'h8A, c);
    chk("rstmid in_fetch rd_en", int'(o_Reg_Rd_En), 1);
    i_Rst_L = 1'b0;
    #1 chk_reset_outputs("rstmid");
    idle(3);
    chk("rstmid tx_during_reset", tx_b.size(), 0);
    chk("rstmid rd_during_reset", rd_a.size(), 0);
    i_Rst_L = 1'b1;
    rel = cyc;
    exp_ovr = 1'b0;
    idle(4);
    ex_tx_b.push_back(8'hA4); ex_tx_c.push_back(rel + 1);
    end_txn("rstmid");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
